// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_pkg
//  Description : Shared HI/LO operation codes and multiply/divide FSM states.
//  Revision    : 1.0
// ============================================================================
package md_pkg;

    // HI/LO-class operation codes, also emitted by the decode controller
    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_MTHI  = 4'd3;
    localparam logic [3:0] MD_MTLO  = 4'd4;
    localparam logic [3:0] MD_DIV   = 4'd5;
    localparam logic [3:0] MD_DIVU  = 4'd6;

    localparam logic [0:0] MD_IDLE  = 1'b0;
    localparam logic [0:0] MD_RUN   = 1'b1;

    function automatic logic md_is_calc(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic int md_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_calc.sv
`default_nettype none
// ============================================================================
//  Module      : md_calc
//  Description : Combinational multiply/divide datapath producing HI/LO values.
//  Revision    : 1.0
// ============================================================================
module md_calc (
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        div_zero
);
    import md_pkg::*;

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Low 64 bits of a product of sign-extended operands equal the signed product
    assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    // Divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000
    assign w_signed = (op == MD_DIV);
    assign w_a_neg  = w_signed & a[31];
    assign w_b_neg  = w_signed & b[31];
    assign w_a_mag  = w_a_neg ? (~a + 32'd1) : a;
    assign w_b_mag  = (b == 32'd0) ? 32'd1 : (w_b_neg ? (~b + 32'd1) : b);
    assign w_q_mag  = w_a_mag / w_b_mag;
    assign w_r_mag  = w_a_mag % w_b_mag;
    assign w_quot   = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem    = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    assign div_zero = md_is_div(op) && (b == 32'd0);

    always_comb begin
        hi_res = 32'd0;
        lo_res = 32'd0;
        case (op)
            MD_MULT: begin
                hi_res = w_prod_s[63:32];
                lo_res = w_prod_s[31:0];
            end
            MD_MULTU: begin
                hi_res = w_prod_u[63:32];
                lo_res = w_prod_u[31:0];
            end
            MD_DIV, MD_DIVU: begin
                hi_res = w_rem;
                lo_res = w_quot;
            end
            default: begin
                hi_res = 32'd0;
                lo_res = 32'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit
//  Description : EX-stage multiply/divide unit owning HI/LO with a fixed busy period.
//  Revision    : 1.0
// ============================================================================
module md_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    import md_pkg::*;

    localparam int c_cnt_w = $clog2(md_max(MUL_CYCLES, DIV_CYCLES) + 1);

    logic [0:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [31:0]        r_pend_hi;
    logic [31:0]        r_pend_lo;
    logic               r_pend_skip;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic [31:0]        w_hi_res;
    logic [31:0]        w_lo_res;
    logic               w_div_zero;
    logic               w_start;
    logic [c_cnt_w-1:0] w_cycles;

    md_calc u_calc (
        .op       (op),
        .a        (rs_val),
        .b        (rt_val),
        .hi_res   (w_hi_res),
        .lo_res   (w_lo_res),
        .div_zero (w_div_zero)
    );

    assign w_start  = (r_state == MD_IDLE) && md_is_calc(op);
    assign w_cycles = md_is_div(op) ? c_cnt_w'(DIV_CYCLES) : c_cnt_w'(MUL_CYCLES);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= MD_IDLE;
            r_cnt       <= '0;
            r_pend_hi   <= 32'd0;
            r_pend_lo   <= 32'd0;
            r_pend_skip <= 1'b0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (w_start) begin
                        r_state     <= MD_RUN;
                        r_cnt       <= w_cycles;
                        r_pend_hi   <= w_hi_res;
                        r_pend_lo   <= w_lo_res;
                        r_pend_skip <= w_div_zero;
                    end else if (op == MD_MTHI) begin
                        r_hi <= rs_val;
                    end else if (op == MD_MTLO) begin
                        r_lo <= rs_val;
                    end
                end
                MD_RUN: begin
                    // Ops presented here are dropped; hazard logic should have stalled them
                    if (r_cnt == c_cnt_w'(1)) begin
                        r_state <= MD_IDLE;
                        r_cnt   <= '0;
                        if (!r_pend_skip) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                default: begin
                    r_state <= MD_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign start = w_start;
    assign busy  = (r_state == MD_RUN);
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_unit
//  Description : Scoreboard bench for md_unit: arithmetic, timing, ignore and reset.
//  Revision    : 1.0
// ============================================================================
module tb_md_unit;
    import md_pkg::*;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  op      = MD_NONE;
    logic [31:0] rs_val  = 32'd0;
    logic [31:0] rt_val  = 32'd0;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    md_unit #(
        .MUL_CYCLES (MUL_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .start   (start),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sbv;
        longint      q;
        longint      r;
        logic [63:0] p;
        e.hi = m_hi;
        e.lo = m_lo;
        sa   = longint'($signed(a));
        sbv  = longint'($signed(b));
        case (o)
            MD_MULT: begin
                p    = 64'(sa * sbv);
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            MD_MULTU: begin
                p    = {32'd0, a} * {32'd0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            MD_DIV: if (b != 32'd0) begin
                q    = sa / sbv;
                r    = sa % sbv;
                e.lo = q[31:0];
                e.hi = r[31:0];
            end
            MD_DIVU: if (b != 32'd0) begin
                e.lo = a / b;
                e.hi = a % b;
            end
            default: ;
        endcase
        return e;
    endfunction

    // Presents op for one cycle from idle; returns in cycle 1 with op cleared
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        op = o; rs_val = a; rt_val = b;
        #1;
        chk({tag, " start"}, 32'(start), 32'(md_is_calc(o)));
        chk({tag, " idle"}, 32'(busy), 32'd0);
        if (md_is_calc(o)) sb.push_back(model(o, a, b));
        @(posedge clk); #1;
        if (o == MD_MTHI) m_hi = a;
        if (o == MD_MTLO) m_lo = a;
        op = MD_NONE; rs_val = $urandom; rt_val = $urandom;
    endtask

    task automatic wait_done(input int exp_cycles, input string tag);
        int   n = 0;
        exp_t e;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        chk({tag, " busy cycles"}, 32'(n), 32'(exp_cycles));
        if (sb.size() == 0) begin
            chk({tag, " scoreboard entry"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, " hi"}, hi, e.hi);
            chk({tag, " lo"}, lo, e.lo);
            m_hi = e.hi;
            m_lo = e.lo;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        repeat (2) @(posedge clk);
        #1;
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset start", 32'(start), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, "mult");
        wait_done(MUL_N, "mult");
        chk("mult hi const", hi, 32'hFFFF_FFFF);
        chk("mult lo const", lo, 32'hFFFF_FFFA);

        issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3, "multu");
        wait_done(MUL_N, "multu");
        chk("multu hi const", hi, 32'h0000_0002);

        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, "div");
        wait_done(DIV_N, "div");
        chk("div lo const", lo, 32'hFFFF_FFFD);
        chk("div hi const", hi, 32'hFFFF_FFFF);

        issue(MD_DIVU, 32'd7, 32'd2, "divu");
        wait_done(DIV_N, "divu");

        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
        wait_done(DIV_N, "div ovf");
        chk("div ovf lo const", lo, 32'h8000_0000);

        // Back-to-back MTHI then MTLO
        op = MD_MTHI; rs_val = 32'hDEAD_BEEF;
        #1 chk("mthi start", 32'(start), 32'd0);
        @(posedge clk); #1;
        chk("mthi hi", hi, 32'hDEAD_BEEF);
        chk("mthi busy", 32'(busy), 32'd0);
        op = MD_MTLO; rs_val = 32'h1234_5678;
        #1 chk("mtlo start", 32'(start), 32'd0);
        @(posedge clk); #1;
        chk("mtlo lo", lo, 32'h1234_5678);
        chk("mtlo hi kept", hi, 32'hDEAD_BEEF);
        chk("mtlo busy", 32'(busy), 32'd0);
        op = MD_NONE;
        m_hi = 32'hDEAD_BEEF; m_lo = 32'h1234_5678;

        issue(MD_MTHI, 32'h11, 32'd0, "pre hi");
        issue(MD_MTLO, 32'h22, 32'd0, "pre lo");
        issue(MD_DIVU, 32'd5, 32'd0, "divu zero");
        wait_done(DIV_N, "divu zero");
        chk("divu zero hi const", hi, 32'h11);
        chk("divu zero lo const", lo, 32'h22);

        // Ops presented during busy must be dropped
        issue(MD_MULT, 32'd1234, 32'd5678, "mult busy");
        @(posedge clk); #1;
        op = MD_MTLO; rs_val = 32'h0000_FFFF;
        #1 chk("ignored mtlo start", 32'(start), 32'd0);
        @(posedge clk); #1;
        op = MD_DIV; rs_val = 32'd9; rt_val = 32'd2;
        #1 chk("ignored div start", 32'(start), 32'd0);
        @(posedge clk); #1;
        op = MD_NONE;
        wait_done(MUL_N - 3, "mult busy");

        for (int i = 0; i < 8; i++) begin
            case (i % 4)
                0:       ro = MD_MULT;
                1:       ro = MD_MULTU;
                2:       ro = MD_DIV;
                default: ro = MD_DIVU;
            endcase
            ra = $urandom;
            rb = (i >= 4) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i == 6) rb = 32'hFFFF_FFF3;
            issue(ro, ra, rb, "rand");
            wait_done(md_is_div(ro) ? DIV_N : MUL_N, "rand");
        end

        // Asynchronous reset in the middle of a divide
        issue(MD_MTHI, 32'hA5A5_A5A5, 32'd0, "pre rst");
        issue(MD_DIV, 32'd100, 32'd7, "div rst");
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        sb.delete();
        m_hi = 32'd0; m_lo = 32'd0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (DIV_N + 2) @(posedge clk);
        #1;
        chk("post rst busy", 32'(busy), 32'd0);
        chk("post rst hi", hi, 32'd0);
        chk("post rst lo", lo, 32'd0);

        issue(MD_MULTU, 32'h0001_0000, 32'h0001_0000, "recover");
        wait_done(MUL_N, "recover");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
